// File: rtl/fix2tfp_stream.sv
// fix2tfp_stream: multi-lane fixed-point to {mantissa, exponent} converter with a valid/ready pipeline
module fix2tfp_stream #(
  parameter int    TFP_WIDTH = 8,
  parameter int    EXP_WIDTH = 3,
  parameter int    FIX_WIDTH = TFP_WIDTH - EXP_WIDTH + 2**EXP_WIDTH - 1,
  parameter int    CHANNELS  = 2,
  parameter string SIGNREP   = "SIGNED",
  parameter string MODE      = "INDEP",
  parameter int    PIPELINE  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  output logic                            i_ready,
  input  logic [CHANNELS*FIX_WIDTH-1:0]   i_data,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic [CHANNELS*TFP_WIDTH-1:0]   o_data,
  output logic [CHANNELS-1:0]             o_sat
);
  localparam int M       = TFP_WIDTH - EXP_WIDTH;
  localparam int MAX_EXP = 2**EXP_WIDTH - 1;
  localparam int N       = FIX_WIDTH;
  localparam bit IS_S    = SIGNREP == "SIGNED";
  localparam bit SHARED  = MODE == "SHARED";
  localparam logic signed [N+1:0] MAXM = IS_S ? (N+2)'(2**(M-1) - 1) : (N+2)'(2**M - 1);
  function automatic logic [EXP_WIDTH-1:0] chan_exp(input logic [N-1:0] f);
    logic [EXP_WIDTH-1:0] e;
    e = '0;
    for (int i = MAX_EXP - 1; i >= 0; i--)
      if (IS_S ? f[N-1] != f[N-2-i] : f[N-1-i]) e = EXP_WIDTH'(MAX_EXP - i);
    return e;
  endfunction
  function automatic logic [M:0] conv(input logic [N-1:0] f, input logic [EXP_WIDTH-1:0] ex);
    logic signed [N+1:0] r, h;
    r = IS_S ? {{2{f[N-1]}}, f} : {2'b00, f};
    h = (ex == '0) ? '0 : (N+2)'(1) << (ex - 1'b1);
    r = (r + h) >>> ex;
    return (r > MAXM) ? {1'b1, MAXM[M-1:0]} : {1'b0, r[M-1:0]};
  endfunction
  logic [CHANNELS-1:0][EXP_WIDTH-1:0] e;
  logic [EXP_WIDTH-1:0]               emax, ex;
  logic [CHANNELS*TFP_WIDTH-1:0]      d_data;
  logic [CHANNELS-1:0]                d_sat;
  logic [PIPELINE-1:0]                v;
  logic [PIPELINE-1:0][CHANNELS*TFP_WIDTH-1:0] dat;
  logic [PIPELINE-1:0][CHANNELS-1:0]  st;
  logic                               en;
  assign en      = ~o_valid | o_ready;
  assign i_ready = en;
  assign o_valid = v[PIPELINE-1];
  assign o_data  = dat[PIPELINE-1];
  assign o_sat   = st[PIPELINE-1];
  // per-lane exponent search, optional shared maximum, then rounding and saturation
  always_comb begin
    e      = '0;
    emax   = '0;
    ex     = '0;
    d_data = '0;
    d_sat  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      e[c] = chan_exp(i_data[c*N +: N]);
      emax = (e[c] > emax) ? e[c] : emax;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      ex = SHARED ? emax : e[c];
      {d_sat[c], d_data[c*TFP_WIDTH+EXP_WIDTH +: M]} = conv(i_data[c*N +: N], ex);
      d_data[c*TFP_WIDTH +: EXP_WIDTH] = ex;
    end
  end
  // lock-step pipeline: every stage advances together when the output can move
  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      dat <= '0;
      st  <= '0;
    end else if (en) begin
      v[0]   <= i_valid;
      dat[0] <= d_data;
      st[0]  <= d_sat;
      for (int i = 1; i < PIPELINE; i++) begin
        v[i]   <= v[i-1];
        dat[i] <= dat[i-1];
        st[i]  <= st[i-1];
      end
    end
  end
endmodule
